// File: rtl/tpc_warp_dispatch.sv
// Warp dispatcher: accepts a kernel launch, issues one SM request per warp,
// collects per-warp completions by id and pulses kernel_done_o when all have returned.
module tpc_warp_dispatch #(
  parameter int NUM_WARP        = 8,
  parameter int DEPTH_WARP      = 3,
  parameter int CODE_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       kernel_valid_i,
  output logic                       kernel_ready_o,
  input  logic [CODE_ADDR_WIDTH-1:0] kernel_start_addr_i,
  input  logic [DEPTH_WARP:0]        kernel_num_warp_i,
  output logic                       sm_req_valid_o,
  input  logic                       sm_req_ready_i,
  output logic [CODE_ADDR_WIDTH-1:0] sm_req_start_addr_o,
  input  logic                       sm_rsp_valid_i,
  output logic                       sm_rsp_ready_o,
  input  logic [DEPTH_WARP-1:0]      sm_rsp_wid_i,
  output logic                       kernel_done_o,
  output logic                       busy_o,
  output logic                       err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [DEPTH_WARP:0] MAX_CNT = (DEPTH_WARP+1)'(NUM_WARP);
  localparam logic [DEPTH_WARP:0] CNT_ONE = (DEPTH_WARP+1)'(1);

  state_t                     state_reg, state_next;
  logic [CODE_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DEPTH_WARP:0]        num_reg, num_next;
  logic [DEPTH_WARP:0]        issue_cnt_reg, issue_cnt_next;
  logic [DEPTH_WARP:0]        rsp_cnt_reg, rsp_cnt_next;
  logic [NUM_WARP-1:0]        mask_reg, mask_next;
  logic                       err_reg, err_next;

  logic ready_reg, ready_next;
  logic req_valid_reg, req_valid_next;
  logic rsp_ready_reg, rsp_ready_next;
  logic done_reg, done_next;
  logic busy_reg, busy_next;

  logic [NUM_WARP-1:0] wid_onehot;
  logic                launch_hs, req_hs, rsp_hs, rsp_dup;

  for (genvar gi = 0; gi < NUM_WARP; gi++) begin : g_wid_dec
    assign wid_onehot[gi] = (sm_rsp_wid_i == DEPTH_WARP'(gi));
  end

  assign launch_hs = kernel_valid_i && ready_reg;
  assign req_hs    = req_valid_reg && sm_req_ready_i;
  assign rsp_hs    = sm_rsp_valid_i && rsp_ready_reg;
  assign rsp_dup   = |(wid_onehot & mask_reg);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    num_next       = num_reg;
    issue_cnt_next = issue_cnt_reg;
    rsp_cnt_next   = rsp_cnt_reg;
    mask_next      = mask_reg;
    err_next       = err_reg;

    // Responses are only possible in ISSUE/DRAIN, so this never collides with a launch.
    if (rsp_hs) begin
      if (rsp_dup) begin
        err_next = 1'b1;
      end else begin
        mask_next    = mask_reg | wid_onehot;
        rsp_cnt_next = rsp_cnt_reg + CNT_ONE;
      end
    end

    case (state_reg)
      IDLE: begin
        if (launch_hs) begin
          addr_next      = kernel_start_addr_i;
          issue_cnt_next = '0;
          rsp_cnt_next   = '0;
          mask_next      = '0;
          if (kernel_num_warp_i == '0) begin
            num_next   = '0;
            state_next = DONE;
          end else if (kernel_num_warp_i > MAX_CNT) begin
            num_next   = MAX_CNT;
            err_next   = 1'b1;
            state_next = ISSUE;
          end else begin
            num_next   = kernel_num_warp_i;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (req_hs) begin
          issue_cnt_next = issue_cnt_reg + CNT_ONE;
          if (issue_cnt_next == num_reg) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rsp_cnt_next == num_reg) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_reg.
    ready_next     = (state_next == IDLE);
    req_valid_next = (state_next == ISSUE);
    rsp_ready_next = ((state_next == ISSUE) || (state_next == DRAIN)) &&
                     (rsp_cnt_next < issue_cnt_next);
    done_next      = (state_next == DONE);
    busy_next      = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      num_reg       <= '0;
      issue_cnt_reg <= '0;
      rsp_cnt_reg   <= '0;
      mask_reg      <= '0;
      err_reg       <= 1'b0;
      ready_reg     <= 1'b1;
      req_valid_reg <= 1'b0;
      rsp_ready_reg <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      num_reg       <= num_next;
      issue_cnt_reg <= issue_cnt_next;
      rsp_cnt_reg   <= rsp_cnt_next;
      mask_reg      <= mask_next;
      err_reg       <= err_next;
      ready_reg     <= ready_next;
      req_valid_reg <= req_valid_next;
      rsp_ready_reg <= rsp_ready_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
    end
  end

  assign kernel_ready_o      = ready_reg;
  assign sm_req_valid_o      = req_valid_reg;
  assign sm_req_start_addr_o = addr_reg;
  assign sm_rsp_ready_o      = rsp_ready_reg;
  assign kernel_done_o       = done_reg;
  assign busy_o              = busy_reg;
  assign err_o               = err_reg;

endmodule

// File: tb/tb_tpc_warp_dispatch.sv
// Directed bench for tpc_warp_dispatch: request addresses are scoreboarded
// per launch; latency, backpressure, duplicate-id and reset cases checked inline.
module tb_tpc_warp_dispatch;
  localparam int NUM_WARP   = 8;
  localparam int DEPTH_WARP = 3;
  localparam int AW         = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  kernel_valid_i;
  logic                  kernel_ready_o;
  logic [AW-1:0]         kernel_start_addr_i;
  logic [DEPTH_WARP:0]   kernel_num_warp_i;
  logic                  sm_req_valid_o;
  logic                  sm_req_ready_i;
  logic [AW-1:0]         sm_req_start_addr_o;
  logic                  sm_rsp_valid_i;
  logic                  sm_rsp_ready_o;
  logic [DEPTH_WARP-1:0] sm_rsp_wid_i;
  logic                  kernel_done_o;
  logic                  busy_o;
  logic                  err_o;

  tpc_warp_dispatch #(
    .NUM_WARP(NUM_WARP), .DEPTH_WARP(DEPTH_WARP), .CODE_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .kernel_valid_i(kernel_valid_i), .kernel_ready_o(kernel_ready_o),
    .kernel_start_addr_i(kernel_start_addr_i), .kernel_num_warp_i(kernel_num_warp_i),
    .sm_req_valid_o(sm_req_valid_o), .sm_req_ready_i(sm_req_ready_i),
    .sm_req_start_addr_o(sm_req_start_addr_o),
    .sm_rsp_valid_i(sm_rsp_valid_i), .sm_rsp_ready_o(sm_rsp_ready_o),
    .sm_rsp_wid_i(sm_rsp_wid_i),
    .kernel_done_o(kernel_done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int req_hs_cnt = 0;
  int rsp_hs_cnt = 0;
  int done_cnt = 0;
  int launch_cyc = 0, last_req_cyc = 0, last_rsp_cyc = 0, done_cyc = 0;
  bit launch_seen, rsp_seen, both_seen;
  bit auto_rsp = 1'b0;
  int next_wid = 0;
  logic [AW-1:0] req_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then advance to just after the rising edge.
  task automatic step();
    bit req_now;
    @(negedge clk);
    cyc++;
    launch_seen = kernel_valid_i && kernel_ready_o;
    rsp_seen    = sm_rsp_valid_i && sm_rsp_ready_o;
    req_now     = sm_req_valid_o && sm_req_ready_i;
    if (launch_seen) launch_cyc = cyc;
    if (req_now) begin
      req_hs_cnt++;
      last_req_cyc = cyc;
      n_checks++;
      assert (req_q.size() > 0) else begin
        n_errors++;
        $error("FAIL req_beyond_count observed=request #%0d expected=no request", req_hs_cnt);
      end
      if (req_q.size() > 0) chk("req_addr", sm_req_start_addr_o, req_q.pop_front());
    end
    if (rsp_seen) begin
      rsp_hs_cnt++;
      last_rsp_cyc = cyc;
      next_wid++;
    end
    if (req_now && rsp_seen) both_seen = 1'b1;
    if (kernel_done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    $display("cyc=%0d launch=%0b req=%0b rsp=%0b done=%0b err=%0b",
             cyc, launch_seen, req_now, rsp_seen, kernel_done_o, err_o);
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      sm_rsp_valid_i = 1'b1;
      sm_rsp_wid_i   = next_wid[DEPTH_WARP-1:0];
    end
  endtask

  task automatic launch(input int cnt, input logic [AW-1:0] addr, output int waited);
    int n;
    n = (cnt > NUM_WARP) ? NUM_WARP : cnt;
    for (int i = 0; i < n; i++) req_q.push_back(addr);
    kernel_valid_i      = 1'b1;
    kernel_start_addr_i = addr;
    kernel_num_warp_i   = cnt[DEPTH_WARP:0];
    next_wid = 0;
    if (auto_rsp) sm_rsp_wid_i = '0;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!launch_seen && waited < 20);
    chk("launch_accepted", launch_seen, 1);
    kernel_valid_i = 1'b0;
  endtask

  task automatic run_until_done(input int max_cyc);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < max_cyc) begin
      step();
      n++;
    end
    chk("done_seen", done_cnt - start, 1);
    chk("done_one_cycle", kernel_done_o, 0);
  endtask

  task automatic send_rsp(input int wid);
    int n;
    sm_rsp_valid_i = 1'b1;
    sm_rsp_wid_i   = wid[DEPTH_WARP-1:0];
    n = 0;
    do begin
      step();
      n++;
    end while (!rsp_seen && n < 20);
    chk("rsp_accepted", rsp_seen, 1);
    sm_rsp_valid_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_kernel_ready"}, kernel_ready_o, 1);
    chk({tag, "_req_valid"}, sm_req_valid_o, 0);
    chk({tag, "_req_addr"}, sm_req_start_addr_o, 0);
    chk({tag, "_rsp_ready"}, sm_rsp_ready_o, 0);
    chk({tag, "_done"}, kernel_done_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    int waited, base_req, base_rsp, base_done, rsp6_cyc;
    rst_n               = 1'b0;
    kernel_valid_i      = 1'b0;
    kernel_start_addr_i = '0;
    kernel_num_warp_i   = '0;
    sm_req_ready_i      = 1'b0;
    sm_rsp_valid_i      = 1'b0;
    sm_rsp_wid_i        = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic: 4 warps at 0x100, ready and responses always available.
    sm_req_ready_i = 1'b1;
    auto_rsp       = 1'b1;
    sm_rsp_valid_i = 1'b1;
    base_req = req_hs_cnt; base_rsp = rsp_hs_cnt; both_seen = 1'b0;
    launch(4, 32'h100, waited);
    chk("basic_busy", busy_o, 1);
    run_until_done(40);
    chk("basic_req_count", req_hs_cnt - base_req, 4);
    chk("basic_rsp_count", rsp_hs_cnt - base_rsp, 4);
    chk("basic_done_after_last_rsp", done_cyc - last_rsp_cyc, 1);
    chk("basic_req_and_rsp_same_cycle", both_seen, 1);
    chk("basic_err", err_o, 0);
    chk("basic_queue_empty", req_q.size(), 0);

    // Minimum latency, single warp.
    launch(1, 32'h180, waited);
    run_until_done(20);
    chk("lat_req_cycle", last_req_cyc - launch_cyc, 1);
    chk("lat_rsp_cycle", last_rsp_cyc - launch_cyc, 2);
    chk("lat_done_cycle", done_cyc - launch_cyc, 3);

    // Backpressure: request ready low for 5 cycles; early responses must be refused.
    sm_req_ready_i = 1'b0;
    base_req = req_hs_cnt; base_rsp = rsp_hs_cnt;
    launch(3, 32'h200, waited);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid_held", sm_req_valid_o, 1);
      chk("bp_addr_stable", sm_req_start_addr_o, 32'h200);
      chk("bp_early_rsp_ready", sm_rsp_ready_o, 0);
      step();
    end
    sm_req_ready_i = 1'b1;
    run_until_done(40);
    chk("bp_req_count", req_hs_cnt - base_req, 3);
    chk("bp_rsp_count", rsp_hs_cnt - base_rsp, 3);

    // Zero-warp launch completes immediately.
    base_req = req_hs_cnt;
    launch(0, 32'h300, waited);
    run_until_done(10);
    chk("zero_done_latency", done_cyc - launch_cyc, 1);
    chk("zero_req_count", req_hs_cnt - base_req, 0);
    chk("zero_err", err_o, 0);

    // Overflow launch is clamped to NUM_WARP and flags an error.
    base_req = req_hs_cnt; base_rsp = rsp_hs_cnt;
    launch(NUM_WARP + 1, 32'h340, waited);
    chk("ovf_err", err_o, 1);
    run_until_done(60);
    chk("ovf_req_count", req_hs_cnt - base_req, NUM_WARP);
    chk("ovf_rsp_count", rsp_hs_cnt - base_rsp, NUM_WARP);
    chk("ovf_err_sticky", err_o, 1);

    // Reset mid-DRAIN: 4 warps issued, 2 returned.
    auto_rsp       = 1'b0;
    sm_rsp_valid_i = 1'b0;
    launch(4, 32'h400, waited);
    send_rsp(0);
    send_rsp(1);
    repeat (3) step();
    chk("drain_busy", busy_o, 1);
    chk("drain_req_valid", sm_req_valid_o, 0);
    chk("drain_rsp_ready", sm_rsp_ready_o, 1);
    base_done = done_cnt;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (2) step();
    chk("mid_reset_no_done", done_cnt - base_done, 0);
    rst_n          = 1'b1;
    auto_rsp       = 1'b1;
    sm_rsp_valid_i = 1'b1;
    launch(1, 32'h500, waited);
    chk("post_reset_launch_cycles", waited, 1);
    run_until_done(20);
    chk("post_reset_err", err_o, 0);

    // Duplicate wid: 5, 5, 6 for a 2-warp kernel.
    auto_rsp       = 1'b0;
    sm_rsp_valid_i = 1'b0;
    launch(2, 32'h600, waited);
    base_done = done_cnt;
    send_rsp(5);
    send_rsp(5);
    chk("dup_err", err_o, 1);
    chk("dup_no_done_yet", done_cnt - base_done, 0);
    chk("dup_still_busy", busy_o, 1);
    send_rsp(6);
    rsp6_cyc = last_rsp_cyc;
    run_until_done(10);
    chk("dup_done_after_wid6", done_cyc - rsp6_cyc, 1);
    chk("dup_queue_empty", req_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tpc_warp_dispatch.md
TPC_WARP_DISPATCH -- requirements
Module: tpc_warp_dispatch

Interface
REQ-001 Parameter NUM_WARP, default 8: maximum number of warps per kernel; this is also the SM warp slot count.
REQ-002 Parameter DEPTH_WARP, default 3: warp-id width, equal to log2(NUM_WARP).
REQ-003 Parameter CODE_ADDR_WIDTH, default 32: kernel start-address width.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 kernel_valid_i  input  1  kernel launch request from the host/GPC.
REQ-007 kernel_ready_o  output  1  dispatcher accepts a launch.
REQ-008 kernel_start_addr_i  input  CODE_ADDR_WIDTH  kernel code start address.
REQ-009 kernel_num_warp_i  input  DEPTH_WARP+1  warps to launch; valid range 0..NUM_WARP.
REQ-010 sm_req_valid_o  output  1  warp request to the SM core (connects to tpc_req_valid_i).
REQ-011 sm_req_ready_i  input  1  SM core can accept a warp (connects to tpc_req_ready_o).
REQ-012 sm_req_start_addr_o  output  CODE_ADDR_WIDTH  start address sent with each warp request.
REQ-013 sm_rsp_valid_i  input  1  SM reports a finished warp.
REQ-014 sm_rsp_ready_o  output  1  dispatcher accepts a warp response.
REQ-015 sm_rsp_wid_i  input  DEPTH_WARP  warp id of the finished warp.
REQ-016 kernel_done_o  output  1  one-cycle pulse when every warp of the kernel has returned.
REQ-017 busy_o  output  1  high in every state except IDLE.
REQ-018 err_o  output  1  sticky error: a duplicate warp id was returned, or the launch count exceeded NUM_WARP.

Function
REQ-019 The block SHALL implement four FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-020 kernel_ready_o SHALL be 1 only in IDLE; a launch handshake is kernel_valid_i && kernel_ready_o.
REQ-021 On launch handshake: latch the address and count, clear the issue counter, response counter and returned-wid mask.
- count 0 -> go to DONE.
- count > NUM_WARP -> set err_o and latch NUM_WARP as the count, then go to ISSUE.
- otherwise -> go to ISSUE.
REQ-022 In ISSUE, sm_req_valid_o SHALL be 1, and sm_req_start_addr_o SHALL hold the latched address and stay stable while valid is high and ready is low.
REQ-023 On each request handshake, the issue counter SHALL increment; on the handshake that makes issue count equal the latched count, the FSM SHALL go to DRAIN the next cycle.
REQ-024 sm_req_valid_o SHALL be 0 in IDLE, DRAIN and DONE; no request is issued beyond the latched count.
REQ-025 sm_rsp_ready_o SHALL equal (state is ISSUE or DRAIN) && (response count < issue count), using registered counts.
- A response therefore cannot be accepted before its request has been issued.
REQ-026 On a response handshake with a new wid: set the mask bit and increment the response counter.
- If the wid's mask bit is already set: set err_o and do not count the response.
REQ-027 A request handshake and a response handshake in the same cycle SHALL both be counted.
REQ-028 DRAIN SHALL go to DONE on the cycle the response count reaches the latched count, i.e. the next state is computed from the incremented count.
REQ-029 In DONE, kernel_done_o SHALL be 1 for exactly one cycle; the FSM then returns to IDLE unconditionally.
REQ-030 Minimum latency for count 1 with ready and response always available:
- cycle 0: launch accepted;
- cycle 1: request handshake;
- cycle 2: response handshake;
- cycle 3: kernel_done_o = 1.
REQ-031 Counters SHALL be DEPTH_WARP+1 bits wide and cannot wrap within a kernel.
REQ-032 err_o SHALL stay set until reset, independent of later kernels.

Reset
REQ-033 While rst_n = 0, and asynchronously on assertion:
- FSM goes to IDLE; counters, mask and latched registers clear;
- kernel_ready_o = 1 once the FSM is in IDLE; all other outputs, including err_o, are 0.
REQ-034 Reset asserted mid-kernel SHALL abandon the kernel with no kernel_done_o pulse; the first cycle after release SHALL accept a new launch.

Verification
REQ-035 Basic: launch count 4, addr 0x100, ready and response always available.
- Expect 4 requests, each with addr 0x100.
- Expect responses wid 0..3 accepted.
- Expect kernel_done_o one cycle after the 4th response; err_o = 0.
REQ-036 Backpressure: count 3, sm_req_ready_i low for 5 cycles.
- Expect valid held high with the address stable throughout.
- Expect exactly 3 request handshakes total.
REQ-037 Zero/overflow launch:
- Count 0 -> kernel_done_o in the cycle after acceptance, no requests.
- Count NUM_WARP+1 -> err_o = 1 and exactly NUM_WARP requests.
REQ-038 Duplicate: count 2, responses wid 5, 5, 6.
- Expect err_o = 1.
- Expect kernel_done_o only after wid 6 is accepted.
REQ-039 Early/simultaneous: response valid before any issue -> sm_rsp_ready_o = 0; a request and a response handshake in the same cycle are both counted.
REQ-040 Reset mid-DRAIN: count 4, 2 responses returned, then pulse rst_n.
- Expect all outputs at reset values and no done pulse.
- Expect a new launch accepted on the next cycle.
